// File: rtl/msdf_otf_converter_pkg.sv
// Shared MSDF definitions: converter state encoding and the borrow-save
// signed-digit encoding used on the multiplier's z_j stream.
package msdf_otf_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SD_POS = 2'b10;
  localparam logic [1:0] SD_NEG = 2'b01;

  // Digit value p - n; both zero encodings (00, 11) map to 0.
  function automatic logic signed [1:0] sd_value(input logic p, input logic n);
    return $signed({1'b0, p}) - $signed({1'b0, n});
  endfunction

endpackage

// File: rtl/msdf_otf_qreg.sv
// On-the-fly conversion step: next Q/QM pair for one radix-2 signed digit.
// QM tracks Q-1 so a negative digit never needs a borrow chain.
module msdf_otf_qreg
  import msdf_otf_converter_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic         zj_p,
  input  logic         zj_n,
  output logic [W-1:0] q_nxt,
  output logic [W-1:0] qm_nxt
);

  logic signed [1:0] dval;

  always_comb begin
    dval   = sd_value(zj_p, zj_n);
    q_nxt  = {q[W-2:0], 1'b0};
    qm_nxt = {qm[W-2:0], 1'b1};
    case (dval)
      2'sb01: begin
        q_nxt  = {q[W-2:0], 1'b1};
        qm_nxt = {q[W-2:0], 1'b0};
      end
      2'sb11: begin
        q_nxt  = {qm[W-2:0], 1'b1};
        qm_nxt = {qm[W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msdf_otf_converter.sv
// MSDF digit stream to two's-complement word converter with a
// valid/ready result port; result is the fraction scaled by 2^N.
module msdf_otf_converter
  import msdf_otf_converter_pkg::*;
#(
  parameter int N     = 9,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             zj_valid,
  input  logic             zj_p,
  input  logic             zj_n,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [N:0]       result,
  output logic             busy,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             err_extra
);

  state_t     state, state_nxt;
  logic [N:0] q, qm, q_nxt, qm_nxt;
  logic       digit_acc;
  logic       last_digit;

  assign digit_acc  = zj_valid && (state == ST_RUN) && !start;
  assign last_digit = (digit_cnt == CNT_W'(N - 1));

  msdf_otf_qreg #(.W(N + 1)) u_qreg (
    .q      (q),
    .qm     (qm),
    .zj_p   (zj_p),
    .zj_n   (zj_n),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (digit_acc && last_digit) state_nxt = ST_DONE;
        ST_DONE: if (res_ready) state_nxt = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // Start clears everything, including a pending result and the error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= '0;
      qm        <= '1;
      digit_cnt <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      err_extra <= 1'b0;
    end else if (start) begin
      q         <= '0;
      qm        <= '1;
      digit_cnt <= '0;
      res_valid <= 1'b0;
      err_extra <= 1'b0;
    end else if (digit_acc) begin
      q         <= q_nxt;
      qm        <= qm_nxt;
      digit_cnt <= digit_cnt + CNT_W'(1);
      if (last_digit) begin
        result    <= q_nxt;
        res_valid <= 1'b1;
      end
    end else if (state == ST_DONE) begin
      if (zj_valid)  err_extra <= 1'b1;
      if (res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Directed bench for msdf_otf_converter with hand-computed result words.
module tb_msdf_otf_converter;

  localparam int N     = 9;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             zj_valid = 1'b0;
  logic             zj_p = 1'b0;
  logic             zj_n = 1'b0;
  logic             res_ready = 1'b0;
  logic             res_valid;
  logic [N:0]       result;
  logic             busy;
  logic [CNT_W-1:0] digit_cnt;
  logic             err_extra;

  int checks = 0;
  int errors = 0;

  msdf_otf_converter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .zj_valid  (zj_valid),
    .zj_p      (zj_p),
    .zj_n      (zj_n),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .result    (result),
    .busy      (busy),
    .digit_cnt (digit_cnt),
    .err_extra (err_extra)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All drivers change just after a falling edge; outputs are read there too.
  task automatic digit(input logic p, input logic n);
    zj_valid = 1'b1; zj_p = p; zj_n = n;
    @(negedge clk);
    zj_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    zj_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [1:0] mix_pat [9];
  int         gap;

  initial begin
    mix_pat = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};

    repeat (2) @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_cnt",       32'(digit_cnt), 32'd0);
    chk("rst_err",       32'(err_extra), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Nine +1 digits back-to-back
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      digit(1'b1, 1'b0);
      if (i == N - 2) chk("t1_not_yet", 32'(res_valid), 32'd0);
    end
    chk("t1_valid",  32'(res_valid), 32'd1);
    chk("t1_result", 32'(result),    32'h1FF);
    chk("t1_cnt",    32'(digit_cnt), 32'd9);
    chk("t1_busy_d", 32'(busy),      32'd0);
    consume();
    chk("t1_consumed", 32'(res_valid), 32'd0);
    chk("t1_keep",     32'(result),    32'h1FF);

    // Digits in IDLE are ignored without error
    digit(1'b0, 1'b1);
    chk("idle_err", 32'(err_extra), 32'd0);
    chk("idle_cnt", 32'(digit_cnt), 32'd9);

    // Nine -1 digits
    do_start();
    for (int i = 0; i < N; i++) digit(1'b0, 1'b1);
    chk("t2_result", 32'(result),    32'h201);
    chk("t2_valid",  32'(res_valid), 32'd1);
    consume();

    // +1,-1 then zeros in both encodings, with gaps
    do_start();
    for (int i = 0; i < N; i++) begin
      digit(mix_pat[i][1], mix_pat[i][0]);
      gap = $urandom_range(0, 2);
      if (i == 0) gap = 2;
      idle(gap);
      if (gap > 0) chk("t3_gap_cnt", 32'(digit_cnt), 32'(i + 1));
    end
    chk("t3_result", 32'(result), 32'h080);
    consume();

    // -1 then eight +1, then back-pressure
    do_start();
    digit(1'b0, 1'b1);
    for (int i = 0; i < N - 1; i++) digit(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_res", 32'(result),    32'h3FF);
      chk("t4_hold_vld", 32'(res_valid), 32'd1);
      @(negedge clk);
    end
    consume();
    chk("t4_released", 32'(res_valid), 32'd0);
    chk("t4_idle",     32'(busy),      32'd0);

    // Extra digit in DONE, then start together with res_ready
    do_start();
    for (int i = 0; i < N; i++) digit(1'b1, 1'b0);
    digit(1'b0, 1'b1);
    chk("t5_err",    32'(err_extra), 32'd1);
    chk("t5_result", 32'(result),    32'h1FF);
    chk("t5_cnt",    32'(digit_cnt), 32'd9);
    idle(1);
    chk("t5_sticky", 32'(err_extra), 32'd1);
    start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0;
    chk("t5_busy",  32'(busy),      32'd1);
    chk("t5_clr",   32'(err_extra), 32'd0);
    chk("t5_cnt0",  32'(digit_cnt), 32'd0);
    chk("t5_vld0",  32'(res_valid), 32'd0);

    // Asynchronous reset after four digits
    for (int i = 0; i < 4; i++) digit(1'b1, 1'b0);
    chk("t6_cnt4", 32'(digit_cnt), 32'd4);
    #2 rst = 1'b0;
    #1;
    chk("t6_busy",  32'(busy),      32'd0);
    chk("t6_cnt",   32'(digit_cnt), 32'd0);
    chk("t6_vld",   32'(res_valid), 32'd0);
    chk("t6_res",   32'(result),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Restart mid-run; the digit in the start cycle is ignored
    do_start();
    for (int i = 0; i < 3; i++) digit(1'b0, 1'b1);
    zj_valid = 1'b1; zj_p = 1'b0; zj_n = 1'b1;
    do_start();
    zj_valid = 1'b0;
    chk("t7_cnt0", 32'(digit_cnt), 32'd0);
    for (int i = 0; i < N; i++) digit(1'b1, 1'b0);
    chk("t7_result", 32'(result),    32'h1FF);
    chk("t7_cnt",    32'(digit_cnt), 32'd9);
    chk("t7_valid",  32'(res_valid), 32'd1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
